// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute stage.
//   - ALU_WIDTH    : default operand/result width
//   - ALU_* codes  : 4-bit ALU_control encodings, shared with the ALU decoder
//   - alu_state_e  : execute-stage FSM state encoding
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative unsigned shift-add multiplier and restoring
// divider, one bit per clock, WIDTH iterations per operation.
// Ports:
//   clock, resetn      : clock, asynchronous active-low reset
//   load               : capture a, b and the mode; clears the counter
//   is_div             : mode captured on load (1 = divide, 0 = multiply)
//   step               : perform one iteration
//   a, b               : multiplicand-side/dividend (a), multiplier/divisor (b)
//   last               : the iteration performed this cycle is the final one
//   res_lo, res_hi     : mult -> {hi,lo} product; div -> lo quotient, hi remainder
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    count;
    logic             div_mode;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;

    // Multiply: {hi,lo} starts as {0,a}; add b into hi when lo[0] is set,
    // then shift the carry-extended pair right by one.
    // Divide: {hi,lo} starts as {0,a}; shift left, trial-subtract b from
    // the top, keep the difference when it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_trial = {hi, lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd};
    end

    assign last   = (count == CW'(WIDTH - 1));
    assign res_lo = lo;
    assign res_hi = hi;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            div_mode <= 1'b0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (load) begin
            count    <= '0;
            div_mode <= is_div;
            opnd     <= b;
            hi       <= '0;
            lo       <= a;
        end else if (step) begin
            count <= count + CW'(1);
            if (div_mode) begin
                if (!div_diff[WIDTH]) begin
                    hi <= div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_trial[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_execute.sv
// alu_execute: ALU execute stage. Single-cycle ops complete one cycle after
// the accept edge; mult/div (when ALU_MULDIV_EN is defined) iterate for
// WIDTH cycles in alu_muldiv_seq and complete WIDTH+1 cycles after accept.
// Build option: ALU_MULDIV_EN -- enables the iterative multiplier/divider;
// when undefined, mult/div codes behave as undefined codes.
// Handshake: start is sampled only in IDLE; a request is accepted on the
// rising edge where start=1 and state=IDLE. done pulses for one cycle when
// results are valid; results hold until the next accepted start. start is
// ignored (not queued) whenever busy=1, including the done cycle.
// Ports:
//   clock, resetn           : clock, asynchronous active-low reset
//   start, ALU_control      : request and operation code
//   A, B, shamt             : operands and shift amount
//   busy, done              : status
//   result_lo, result_hi    : result words
//   zero, div_by_zero       : flags, valid with done
//   state_dbg               : current FSM state
module alu_execute
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output alu_state_e       state_dbg
);

    alu_state_e       state;
    alu_state_e       state_next;
    logic             accept;
    logic             is_iter_op;
    logic [WIDTH-1:0] single_lo;
    logic [WIDTH-1:0] single_hi;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;

    assign accept = (state == ST_IDLE) && start;

`ifdef ALU_MULDIV_EN
    logic             single_dbz;
    logic             dbz_q;
    logic             use_seq_q;
    logic             seq_last;
    logic [WIDTH-1:0] seq_lo;
    logic [WIDTH-1:0] seq_hi;

    // Divide by zero bypasses the iterative path entirely.
    assign is_iter_op = (ALU_control == ALU_MUL) ||
                        ((ALU_control == ALU_DIV) && (B != '0));

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .resetn (resetn),
        .load   (accept && is_iter_op),
        .is_div (ALU_control == ALU_DIV),
        .step   (state == ST_ITER),
        .a      (A),
        .b      (B),
        .last   (seq_last),
        .res_lo (seq_lo),
        .res_hi (seq_hi)
    );

    // The sequencer's registers hold the final value after the last step,
    // so they are presented directly instead of being copied.
    assign result_lo   = use_seq_q ? seq_lo : res_lo_q;
    assign result_hi   = use_seq_q ? seq_hi : res_hi_q;
    assign div_by_zero = dbz_q;
`else
    assign is_iter_op  = 1'b0;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = 1'b0;
`endif

    assign zero      = (result_lo == '0);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        single_lo = '0;
        single_hi = '0;
`ifdef ALU_MULDIV_EN
        single_dbz = 1'b0;
`endif
        case (ALU_control)
            ALU_ADD: single_lo = A + B;
            ALU_SUB: single_lo = A - B;
            ALU_AND: single_lo = A & B;
            ALU_OR:  single_lo = A | B;
            ALU_XOR: single_lo = A ^ B;
            ALU_NOR: single_lo = ~(A | B);
            ALU_SLL: single_lo = B << shamt;
            ALU_SRL: single_lo = B >> shamt;
`ifdef ALU_MULDIV_EN
            ALU_DIV: begin
                if (B == '0) begin
                    single_lo  = '1;
                    single_hi  = A;
                    single_dbz = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = is_iter_op ? ST_ITER : ST_DONE;
                end
            end
            ST_ITER: begin
`ifdef ALU_MULDIV_EN
                if (seq_last) begin
                    state_next = ST_DONE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            res_lo_q <= '0;
            res_hi_q <= '0;
`ifdef ALU_MULDIV_EN
            dbz_q     <= 1'b0;
            use_seq_q <= 1'b0;
`endif
        end else if (accept) begin
            res_lo_q <= single_lo;
            res_hi_q <= single_hi;
`ifdef ALU_MULDIV_EN
            dbz_q     <= single_dbz;
            use_seq_q <= is_iter_op;
`endif
        end
    end

endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: directed-vector bench for alu_execute. Expectations are
// hand-computed constants; mult/div expectations follow ALU_MULDIV_EN.
module tb_alu_execute;
    import alu_pkg::*;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  ALU_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        zero;
    logic        div_by_zero;
    alu_state_e  state_dbg;

    int checks   = 0;
    int failures = 0;
    int lat;
    int done_seen;

    alu_execute #(.WIDTH(32)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .ALU_control (ALU_control),
        .A           (A),
        .B           (B),
        .shamt       (shamt),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for IDLE, issues one request, scrambles inputs after the accept
    // edge, and returns the cycle count from accept until done is seen.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int latency);
        int guard;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        ALU_control = op;
        A           = a;
        B           = b;
        shamt       = sh;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        A           = $urandom;
        B           = $urandom;
        shamt       = 5'($urandom_range(0, 31));
        ALU_control = 4'($urandom_range(0, 15));
        latency = 1;
        while (!done && latency < 100) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    task automatic expect_res(input string tag, input int latency, input int exp_lat,
                              input logic [31:0] lo, input logic [31:0] hi,
                              input logic z, input logic dbz);
        check({tag, "_lat"}, 64'(latency), 64'(exp_lat));
        check({tag, "_lo"},  64'(result_lo), 64'(lo));
        check({tag, "_hi"},  64'(result_hi), 64'(hi));
        check({tag, "_zero"}, 64'(zero), 64'(z));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_lo"},   64'(result_lo), 64'(0));
        check({tag, "_hi"},   64'(result_hi), 64'(0));
        check({tag, "_zero"}, 64'(zero), 64'(1));
        check({tag, "_dbz"},  64'(div_by_zero), 64'(0));
        check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        ALU_control = 4'd0;
        A           = '0;
        B           = '0;
        shamt       = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        resetn = 1'b1;

        // single-cycle ops
        do_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
        expect_res("add_wrap", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        check("add_done_pulse", 64'(done), 64'(0));
        check("add_hold_lo", 64'(result_lo), 64'(0));

        do_op(ALU_SUB, 32'd5, 32'd7, 5'd0, lat);
        expect_res("sub_neg", lat, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
        do_op(ALU_SUB, 32'd0, 32'd1, 5'd0, lat);
        expect_res("sub_wrap", lat, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        do_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, lat);
        expect_res("and", lat, 1, 32'h00F0_0034, 32'h0, 1'b0, 1'b0);
        do_op(ALU_OR, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, lat);
        expect_res("or", lat, 1, 32'hFFF0_12FF, 32'h0, 1'b0, 1'b0);
        do_op(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, lat);
        expect_res("xor", lat, 1, 32'hFF00_12CB, 32'h0, 1'b0, 1'b0);
        do_op(ALU_NOR, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, lat);
        expect_res("nor", lat, 1, 32'h000F_ED00, 32'h0, 1'b0, 1'b0);
        do_op(ALU_SLL, 32'h0, 32'h1, 5'd31, lat);
        expect_res("sll31", lat, 1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        do_op(ALU_SRL, 32'h0, 32'h8000_0000, 5'd31, lat);
        expect_res("srl31", lat, 1, 32'h1, 32'h0, 1'b0, 1'b0);
        do_op(ALU_SLL, 32'h0, 32'h0000_00A5, 5'd4, lat);
        expect_res("sll4", lat, 1, 32'h0000_0A50, 32'h0, 1'b0, 1'b0);
        do_op(4'b1111, 32'h1234, 32'h5678, 5'd3, lat);
        expect_res("undef", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef ALU_MULDIV_EN
        do_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 5'd0, lat);
        expect_res("mul_max", lat, 33, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0);
        do_op(ALU_MUL, 32'h1234_5678, 32'h10, 5'd0, lat);
        expect_res("mul_shift", lat, 33, 32'h2345_6780, 32'h1, 1'b0, 1'b0);
        do_op(ALU_DIV, 32'd100, 32'd7, 5'd0, lat);
        expect_res("div_100_7", lat, 33, 32'd14, 32'd2, 1'b0, 1'b0);
        do_op(ALU_DIV, 32'd5, 32'd0, 5'd0, lat);
        expect_res("div_by0", lat, 1, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1);
        do_op(ALU_DIV, 32'hFFFF_FFFF, 32'h10, 5'd0, lat);
        expect_res("div_big", lat, 33, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
`else
        do_op(ALU_MUL, 32'd3, 32'd4, 5'd0, lat);
        expect_res("mul_off", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
        do_op(ALU_DIV, 32'd5, 32'd0, 5'd0, lat);
        expect_res("div_off", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // start held through the done cycle is ignored there, accepted next
        do_op(ALU_ADD, 32'd10, 32'd20, 5'd0, lat);
        expect_res("add_pre", lat, 1, 32'd30, 32'h0, 1'b0, 1'b0);
        ALU_control = ALU_SUB;
        A           = 32'd50;
        B           = 32'd8;
        start       = 1'b1;
        @(posedge clock);
        #1;
        check("start_in_done_done", 64'(done), 64'(0));
        check("start_in_done_busy", 64'(busy), 64'(0));
        check("start_in_done_hold", 64'(result_lo), 64'(30));
        @(posedge clock);
        #1;
        start = 1'b0;
        check("accept_after_done_done", 64'(done), 64'(1));
        check("accept_after_done_lo", 64'(result_lo), 64'(42));

        // asynchronous reset clears held results immediately
        do_op(ALU_XOR, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, lat);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clock);
        resetn = 1'b1;

`ifdef ALU_MULDIV_EN
        // reset aborts an in-flight mult; a start while busy is dropped
        @(negedge clock);
        ALU_control = ALU_MUL;
        A           = 32'd1000;
        B           = 32'd1000;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("mul_abort_busy", 64'(busy), 64'(1));
        repeat (4) @(posedge clock);
        @(negedge clock);
        ALU_control = ALU_ADD;
        A           = 32'd1;
        B           = 32'd1;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_start_ignored_busy", 64'(busy), 64'(1));
        check("busy_start_ignored_done", 64'(done), 64'(0));
        repeat (4) @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_iter");
        @(negedge clock);
        resetn = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check("rst_iter_no_done", 64'(done_seen), 64'(0));
`endif

        do_op(ALU_ADD, 32'd3, 32'd4, 5'd0, lat);
        expect_res("add_after_rst", lat, 1, 32'd7, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
